// File: rtl/veri_yolu_hakem.sv
// Two-requester arbiter sharing the L1 data-cache port; responses return in order via an ID FIFO.
// Optional round-robin priority: define HAKEM_DONUSUMLU_EN (default build is fixed priority, port 0 wins).
module veri_yolu_hakem #(
  parameter int unsigned ADRES_BIT         = 32,
  parameter int unsigned VERI_BIT          = 32,
  parameter int unsigned MASKE_BIT         = 4,
  parameter int unsigned BEKLEYEN_DERINLIK = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rstn_i,
  input  logic                                   istek0_gecerli_i,
  output logic                                   istek0_hazir_o,
  input  logic [ADRES_BIT-1:0]                   istek0_adres_i,
  input  logic                                   istek0_yaz_i,
  input  logic [VERI_BIT-1:0]                    istek0_veri_i,
  input  logic [MASKE_BIT-1:0]                   istek0_maske_i,
  input  logic                                   istek1_gecerli_i,
  output logic                                   istek1_hazir_o,
  input  logic [ADRES_BIT-1:0]                   istek1_adres_i,
  input  logic                                   istek1_yaz_i,
  input  logic [VERI_BIT-1:0]                    istek1_veri_i,
  input  logic [MASKE_BIT-1:0]                   istek1_maske_i,
  output logic                                   yanit0_gecerli_o,
  output logic [VERI_BIT-1:0]                    yanit0_veri_o,
  input  logic                                   yanit0_hazir_i,
  output logic                                   yanit1_gecerli_o,
  output logic [VERI_BIT-1:0]                    yanit1_veri_o,
  input  logic                                   yanit1_hazir_i,
  output logic                                   l1v_istek_gecerli_o,
  input  logic                                   l1v_istek_hazir_i,
  output logic [ADRES_BIT-1:0]                   l1v_istek_adres_o,
  output logic                                   l1v_istek_yaz_o,
  output logic [VERI_BIT-1:0]                    l1v_istek_veri_o,
  output logic [MASKE_BIT-1:0]                   l1v_istek_maske_o,
  input  logic [VERI_BIT-1:0]                    l1v_veri_i,
  input  logic                                   l1v_veri_gecerli_i,
  output logic                                   l1v_veri_hazir_o,
  output logic [$clog2(BEKLEYEN_DERINLIK):0]     bekleyen_sayi_o,
  output logic                                   hata_o
);

  localparam int unsigned PW = $clog2(BEKLEYEN_DERINLIK);
  localparam int unsigned SW = PW + 1;

  logic [BEKLEYEN_DERINLIK-1:0] id_fifo;
  logic [PW-1:0]                yaz_ptr;
  logic [PW-1:0]                oku_ptr;
  logic [SW-1:0]                sayi;
  logic                         kilit;
  logic                         kilit_id;
  logic                         hata;
`ifdef HAKEM_DONUSUMLU_EN
  logic                         oncelik;
`endif

  logic dolu;
  logic bos;
  logic izin_v;
  logic izin_id;
  logic istek_hs;
  logic bas_id;
  logic yanit_pop;

  // Grant selection: a stalled request keeps its grant; nothing is granted while full.
  always_comb begin
    dolu    = (sayi == SW'(BEKLEYEN_DERINLIK));
    bos     = (sayi == '0);
    izin_v  = 1'b0;
    izin_id = 1'b0;
    if (!dolu) begin
      if (kilit) begin
        izin_id = kilit_id;
        izin_v  = kilit_id ? istek1_gecerli_i : istek0_gecerli_i;
      end else if (istek0_gecerli_i && istek1_gecerli_i) begin
        izin_v  = 1'b1;
`ifdef HAKEM_DONUSUMLU_EN
        izin_id = oncelik;
`else
        izin_id = 1'b0;
`endif
      end else begin
        izin_v  = istek0_gecerli_i | istek1_gecerli_i;
        izin_id = ~istek0_gecerli_i;
      end
    end
  end

  // Downstream request mux and upstream ready.
  always_comb begin
    l1v_istek_gecerli_o = izin_v;
    l1v_istek_adres_o   = izin_id ? istek1_adres_i : istek0_adres_i;
    l1v_istek_yaz_o     = izin_id ? istek1_yaz_i   : istek0_yaz_i;
    l1v_istek_veri_o    = izin_id ? istek1_veri_i  : istek0_veri_i;
    l1v_istek_maske_o   = izin_id ? istek1_maske_i : istek0_maske_i;
    istek0_hazir_o      = izin_v & ~izin_id & l1v_istek_hazir_i;
    istek1_hazir_o      = izin_v &  izin_id & l1v_istek_hazir_i;
    istek_hs            = izin_v & l1v_istek_hazir_i;
  end

  // Response routing to the requester recorded at the FIFO head.
  always_comb begin
    bas_id           = id_fifo[oku_ptr];
    yanit0_gecerli_o = l1v_veri_gecerli_i & ~bos & ~bas_id;
    yanit1_gecerli_o = l1v_veri_gecerli_i & ~bos &  bas_id;
    yanit0_veri_o    = l1v_veri_i;
    yanit1_veri_o    = l1v_veri_i;
    l1v_veri_hazir_o = ~bos & (bas_id ? yanit1_hazir_i : yanit0_hazir_i);
    yanit_pop        = l1v_veri_gecerli_i & l1v_veri_hazir_o;
    bekleyen_sayi_o  = sayi;
    hata_o           = hata;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      id_fifo  <= '0;
      yaz_ptr  <= '0;
      oku_ptr  <= '0;
      sayi     <= '0;
      kilit    <= 1'b0;
      kilit_id <= 1'b0;
      hata     <= 1'b0;
`ifdef HAKEM_DONUSUMLU_EN
      oncelik  <= 1'b0;
`endif
    end else begin
      if (istek_hs) begin
        id_fifo[yaz_ptr] <= izin_id;
        yaz_ptr          <= yaz_ptr + PW'(1);
      end
      if (yanit_pop) begin
        oku_ptr <= oku_ptr + PW'(1);
      end
      if (istek_hs && !yanit_pop) begin
        sayi <= sayi + SW'(1);
      end else if (!istek_hs && yanit_pop) begin
        sayi <= sayi - SW'(1);
      end
      // Lock the grant while downstream stalls a presented request.
      if (istek_hs) begin
        kilit <= 1'b0;
      end else if (izin_v) begin
        kilit    <= 1'b1;
        kilit_id <= izin_id;
      end
      if (l1v_veri_gecerli_i && bos) begin
        hata <= 1'b1;
      end
`ifdef HAKEM_DONUSUMLU_EN
      if (istek_hs) begin
        oncelik <= ~izin_id;
      end
`endif
    end
  end

endmodule

// File: tb/tb_veri_yolu_hakem.sv
// Scoreboard bench for veri_yolu_hakem: reference arbitration/memory model plus a response monitor.
// Honours HAKEM_DONUSUMLU_EN for the expected priority rule.
module tb_veri_yolu_hakem;

  localparam int unsigned DER = 4;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        istek0_gecerli_i, istek1_gecerli_i;
  logic        istek0_hazir_o, istek1_hazir_o;
  logic [31:0] istek0_adres_i, istek1_adres_i;
  logic        istek0_yaz_i, istek1_yaz_i;
  logic [31:0] istek0_veri_i, istek1_veri_i;
  logic [3:0]  istek0_maske_i, istek1_maske_i;
  logic        yanit0_gecerli_o, yanit1_gecerli_o;
  logic [31:0] yanit0_veri_o, yanit1_veri_o;
  logic        yanit0_hazir_i, yanit1_hazir_i;
  logic        l1v_istek_gecerli_o, l1v_istek_hazir_i;
  logic [31:0] l1v_istek_adres_o;
  logic        l1v_istek_yaz_o;
  logic [31:0] l1v_istek_veri_o;
  logic [3:0]  l1v_istek_maske_o;
  logic [31:0] l1v_veri_i;
  logic        l1v_veri_gecerli_i, l1v_veri_hazir_o;
  logic [2:0]  bekleyen_sayi_o;
  logic        hata_o;

  veri_yolu_hakem dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .istek0_gecerli_i(istek0_gecerli_i), .istek0_hazir_o(istek0_hazir_o),
    .istek0_adres_i(istek0_adres_i), .istek0_yaz_i(istek0_yaz_i),
    .istek0_veri_i(istek0_veri_i), .istek0_maske_i(istek0_maske_i),
    .istek1_gecerli_i(istek1_gecerli_i), .istek1_hazir_o(istek1_hazir_o),
    .istek1_adres_i(istek1_adres_i), .istek1_yaz_i(istek1_yaz_i),
    .istek1_veri_i(istek1_veri_i), .istek1_maske_i(istek1_maske_i),
    .yanit0_gecerli_o(yanit0_gecerli_o), .yanit0_veri_o(yanit0_veri_o), .yanit0_hazir_i(yanit0_hazir_i),
    .yanit1_gecerli_o(yanit1_gecerli_o), .yanit1_veri_o(yanit1_veri_o), .yanit1_hazir_i(yanit1_hazir_i),
    .l1v_istek_gecerli_o(l1v_istek_gecerli_o), .l1v_istek_hazir_i(l1v_istek_hazir_i),
    .l1v_istek_adres_o(l1v_istek_adres_o), .l1v_istek_yaz_o(l1v_istek_yaz_o),
    .l1v_istek_veri_o(l1v_istek_veri_o), .l1v_istek_maske_o(l1v_istek_maske_o),
    .l1v_veri_i(l1v_veri_i), .l1v_veri_gecerli_i(l1v_veri_gecerli_i), .l1v_veri_hazir_o(l1v_veri_hazir_o),
    .bekleyen_sayi_o(bekleyen_sayi_o), .hata_o(hata_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Requester state: a request stays valid with a stable payload until accepted.
  bit          rv[2];
  logic [31:0] ra[2];
  bit          ry[2];
  logic [31:0] rd[2];
  logic [3:0]  rm[2];

  // Reference model state.
  bit          m_idq[$];
  bit          m_lock, m_lock_id, m_pri, m_hata;
  logic [31:0] ref_mem[8];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  // L1 environment model.
  logic [31:0] l1_mem[8];
  logic [31:0] l1q[$];

  bit k_l1hz, k_yh0, k_yh1, k_resp_en, k_spur;
  bit dut_gnt;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic new_req(input int n);
    logic [31:0] u;
    u = $urandom();
    ra[n] = (u & 32'hFFFF_FFE0) | (32'($urandom_range(0, 7)) << 2);
    ry[n] = 1'($urandom_range(0, 1));
    rd[n] = $urandom();
    rm[n] = 4'($urandom_range(0, 15));
    rv[n] = 1'b1;
  endtask

  // One clock: drive at posedge+1, check against the model, advance model across the edge.
  task automatic step(input bit rst);
    bit gv, gid, acc, full, ne, head, pop_e, rsp;
    logic [31:0] e;
    logic [2:0] ix;
    rstn_i           = !rst;
    istek0_gecerli_i = rv[0]; istek0_adres_i = ra[0]; istek0_yaz_i = ry[0];
    istek0_veri_i    = rd[0]; istek0_maske_i = rm[0];
    istek1_gecerli_i = rv[1]; istek1_adres_i = ra[1]; istek1_yaz_i = ry[1];
    istek1_veri_i    = rd[1]; istek1_maske_i = rm[1];
    l1v_istek_hazir_i = k_l1hz;
    yanit0_hazir_i    = k_yh0;
    yanit1_hazir_i    = k_yh1;
    if (k_spur) begin
      l1v_veri_gecerli_i = 1'b1; l1v_veri_i = $urandom();
    end else if (k_resp_en && l1q.size() > 0) begin
      l1v_veri_gecerli_i = 1'b1; l1v_veri_i = l1q[0];
    end else begin
      l1v_veri_gecerli_i = 1'b0; l1v_veri_i = $urandom();
    end
    #1;
    if (rst) begin
      @(posedge clk); #1;
      m_idq.delete(); exp_q0.delete(); exp_q1.delete(); l1q.delete();
      m_lock = 0; m_lock_id = 0; m_pri = 0; m_hata = 0;
      rv[0] = 0; rv[1] = 0;
      return;
    end
    full = (m_idq.size() == DER);
    gv = 0; gid = 0;
    if (!full) begin
      if (m_lock) begin gid = m_lock_id; gv = rv[gid]; end
      else if (rv[0] && rv[1]) begin
`ifdef HAKEM_DONUSUMLU_EN
        gid = m_pri;
`else
        gid = 0;
`endif
        gv = 1;
      end else if (rv[0]) begin gid = 0; gv = 1; end
      else if (rv[1]) begin gid = 1; gv = 1; end
    end
    acc  = gv && k_l1hz;
    ne   = (m_idq.size() > 0);
    head = ne ? m_idq[0] : 1'b0;
    rsp  = l1v_veri_gecerli_i;
    pop_e = rsp && ne && (head ? k_yh1 : k_yh0);
    dut_gnt = istek1_hazir_o;
    chk("istek", 128'({l1v_istek_gecerli_o, istek0_hazir_o, istek1_hazir_o}),
        128'({gv, acc && !gid, acc && gid}));
    if (gv)
      chk("yuk", 128'({l1v_istek_adres_o, l1v_istek_yaz_o, l1v_istek_veri_o, l1v_istek_maske_o}),
          128'({ra[gid], ry[gid], rd[gid], rm[gid]}));
    chk("sayi", 128'(bekleyen_sayi_o), 128'(m_idq.size()));
    chk("hata", 128'(hata_o), 128'(m_hata));
    chk("yanit", 128'({yanit0_gecerli_o, yanit1_gecerli_o, l1v_veri_hazir_o}),
        128'({rsp && ne && !head, rsp && ne && head, ne && (head ? k_yh1 : k_yh0)}));
    // L1 side reacts to what the DUT actually forwards.
    if (l1v_istek_gecerli_o && l1v_istek_hazir_i) begin
      ix = l1v_istek_adres_o[4:2];
      if (l1v_istek_yaz_o) l1_mem[ix] = merge(l1_mem[ix], l1v_istek_veri_o, l1v_istek_maske_o);
      l1q.push_back(l1_mem[ix]);
    end
    if (!k_spur && l1v_veri_gecerli_i && l1v_veri_hazir_o) void'(l1q.pop_front());
    // Reference model update.
    if (acc) begin
      ix = ra[gid][4:2];
      if (ry[gid]) ref_mem[ix] = merge(ref_mem[ix], rd[gid], rm[gid]);
      e = ref_mem[ix];
      if (gid) exp_q1.push_back(e); else exp_q0.push_back(e);
      m_idq.push_back(gid);
      rv[gid] = 0;
      m_lock = 0;
      m_pri = ~gid;
    end else if (gv) begin
      m_lock = 1; m_lock_id = gid;
    end
    if (pop_e) void'(m_idq.pop_front());
    if (rsp && !ne) m_hata = 1;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    k_l1hz = 1; k_yh0 = 1; k_yh1 = 1; k_resp_en = 1; k_spur = 0;
    n = 0;
    while ((rv[0] || rv[1] || m_idq.size() != 0) && n < 100) begin
      step(0); n++;
    end
    chk("bosalt", 128'({32'(m_idq.size()), 32'(exp_q0.size() + exp_q1.size()), 32'(l1q.size())}), 128'(0));
  endtask

  // Monitor: pops the expected response queue whenever the DUT hands a response over.
  always @(negedge clk) begin
    if (rstn_i === 1'b1) begin
      if (yanit0_gecerli_o && yanit1_gecerli_o) begin
        tests++; fails++;
        $display("FAIL yanit_cift: both responses valid (t=%0t)", $time);
      end
      if (yanit0_gecerli_o && yanit0_hazir_i) begin
        if (exp_q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL yanit0_fazla: got %0h want none", yanit0_veri_o);
        end else chk("yanit0_veri", 128'(yanit0_veri_o), 128'(exp_q0.pop_front()));
      end
      if (yanit1_gecerli_o && yanit1_hazir_i) begin
        if (exp_q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL yanit1_fazla: got %0h want none", yanit1_veri_o);
        end else chk("yanit1_veri", 128'(yanit1_veri_o), 128'(exp_q1.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL zaman_asimi: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seq[4];
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = (i == 0) ? 32'hDEAD_BEEF : 32'h1111_1111 * 32'(i);
      l1_mem[i]  = ref_mem[i];
    end
    for (int n = 0; n < 2; n++) begin
      rv[n] = 0; ra[n] = 0; ry[n] = 0; rd[n] = 0; rm[n] = 0;
    end
    k_l1hz = 0; k_yh0 = 0; k_yh1 = 0; k_resp_en = 0; k_spur = 0;
    rstn_i = 0;
    @(posedge clk); #1;
    step(1); step(1);
    chk("rst_cikis", 128'({istek0_hazir_o, istek1_hazir_o, l1v_istek_gecerli_o, yanit0_gecerli_o,
                           yanit1_gecerli_o, l1v_veri_hazir_o, hata_o, bekleyen_sayi_o}), 128'(0));

    // Single load to 0x1000 returning 0xDEADBEEF.
    rv[0] = 1; ra[0] = 32'h0000_1000; ry[0] = 0; rd[0] = 0; rm[0] = 0;
    k_l1hz = 1;
    step(0);
    chk("tek_sayi1", 128'(bekleyen_sayi_o), 128'(1));
    k_resp_en = 1; k_yh0 = 1;
    step(0);
    chk("tek_sayi0", 128'(bekleyen_sayi_o), 128'(0));

    // Contention from a fresh reset.
    step(1);
`ifdef HAKEM_DONUSUMLU_EN
    seq[0] = 0; seq[1] = 1; seq[2] = 0; seq[3] = 1;
`else
    seq[0] = 0; seq[1] = 0; seq[2] = 0; seq[3] = 0;
`endif
    k_l1hz = 1; k_resp_en = 0;
    for (int c = 0; c < 4; c++) begin
      for (int n = 0; n < 2; n++) if (!rv[n]) new_req(n);
      step(0);
      chk($sformatf("cekisme%0d", c), 128'(dut_gnt), 128'(seq[c]));
    end
    drain();

    // Lock: port 1 stalls, port 0 arrives in the second cycle.
    k_l1hz = 0; k_resp_en = 0;
    new_req(1);
    step(0);
    new_req(0);
    step(0);
    step(0);
    k_l1hz = 1;
    step(0);
    chk("kilit_hs1", 128'(dut_gnt), 128'(1));
    step(0);
    chk("kilit_sonra0", 128'(dut_gnt), 128'(0));
    drain();

    // Full FIFO, then pop without same-cycle push.
    k_l1hz = 1; k_resp_en = 0;
    for (int c = 0; c < 4; c++) begin new_req(0); step(0); end
    new_req(0);
    step(0);
    chk("dolu_sayi", 128'(bekleyen_sayi_o), 128'(4));
    k_resp_en = 1; k_yh0 = 1;
    step(0);
    chk("dolu_pop", 128'(bekleyen_sayi_o), 128'(3));
    k_resp_en = 0;
    step(0);
    chk("dolu_geri", 128'(bekleyen_sayi_o), 128'(4));
    drain();

    // Response backpressure with port 1 at the head.
    new_req(1); k_l1hz = 1; k_resp_en = 0;
    step(0);
    k_resp_en = 1; k_yh1 = 0;
    step(0); step(0);
    chk("geri_basinc", 128'({l1v_veri_hazir_o, bekleyen_sayi_o}), 128'({1'b0, 3'd1}));
    drain();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      for (int n = 0; n < 2; n++) if (!rv[n] && $urandom_range(0, 1) == 1) new_req(n);
      k_l1hz    = ($urandom_range(0, 3) != 0);
      k_yh0     = ($urandom_range(0, 3) != 0);
      k_yh1     = ($urandom_range(0, 3) != 0);
      k_resp_en = ($urandom_range(0, 2) != 0);
      step(0);
    end
    drain();

    // Response while empty sets the sticky error until reset.
    k_spur = 1;
    step(0);
    k_spur = 0;
    step(0); step(0);
    chk("hata_yapiskan", 128'(hata_o), 128'(1));
    step(1);
    chk("hata_rst", 128'(hata_o), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/veri_yolu_hakem.md
Name: veri_yolu_hakem

Overview:
- Shares the single L1 data-cache request/response port between two requesters.
  - Port 0 is the bellek stage (load/store).
  - Port 1 is the getir stage (instruction fetch path through the veri yolu birimi).
- Arbitrates requests, holds a grant stable until it is accepted, and records the requester ID of each accepted request in an in-order FIFO.
- Routes each L1 response back to the requester at the FIFO head.
- Sits between the pipeline stages and the l1 denetleyici.

Parameters:
- ADRES_BIT, 32, request address width (matches PS_BIT).
- VERI_BIT, 32, data width.
- MASKE_BIT, 4, write byte-mask width (VERI_BIT/8).
- BEKLEYEN_DERINLIK, 4, maximum outstanding accepted requests (power of 2, >=2).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  synchronous active-low reset.
- istek0_gecerli_i / istek1_gecerli_i  in  1  requester N has a request.
- istek0_hazir_o / istek1_hazir_o  out  1  request N accepted this cycle (handshake = gecerli & hazir).
- istek0_adres_i / istek1_adres_i  in  ADRES_BIT  request address.
- istek0_yaz_i / istek1_yaz_i  in  1  1=store, 0=load.
- istek0_veri_i / istek1_veri_i  in  VERI_BIT  store data.
- istek0_maske_i / istek1_maske_i  in  MASKE_BIT  store byte mask.
- yanit0_gecerli_o / yanit1_gecerli_o  out  1  response for requester N valid.
- yanit0_veri_o / yanit1_veri_o  out  VERI_BIT  response data.
- yanit0_hazir_i / yanit1_hazir_i  in  1  requester N can take the response.
- l1v_istek_gecerli_o  out  1  downstream request valid.
- l1v_istek_hazir_i  in  1  downstream ready.
- l1v_istek_adres_o  out  ADRES_BIT.
- l1v_istek_yaz_o  out  1.
- l1v_istek_veri_o  out  VERI_BIT.
- l1v_istek_maske_o  out  MASKE_BIT.
- l1v_veri_i  in  VERI_BIT  response data.
- l1v_veri_gecerli_i  in  1  response valid.
- l1v_veri_hazir_o  out  1  response accepted.
- bekleyen_sayi_o  out  $clog2(BEKLEYEN_DERINLIK)+1  current FIFO occupancy.
- hata_o  out  1  sticky: a response arrived while the FIFO was empty.

Behaviour:
- Reset: rstn_i sampled on posedge clk_i, active low. Reset applies regardless of in-flight traffic; all outstanding entries are discarded. The L1 side shares rstn_i, so no stale responses follow.
  - Registers: FIFO empty, pointers 0, kilit=0, kilit_id=0, oncelik=0, hata=0.
  - Outputs: all *_gecerli_o, *_hazir_o, hata_o and bekleyen_sayi_o read 0.
- Grant (combinational from registered state):
  - If kilit=1, the grant is kilit_id.
  - Otherwise the grant goes to the highest-priority requester with gecerli=1 (see Optional Feature).
  - No grant while the FIFO is full. A pop in the same cycle does not free a slot for a push.
- Downstream request:
  - l1v_istek_gecerli_o = granted requester's gecerli; address/yaz/veri/maske are muxed from the granted requester.
  - istekN_hazir_o = (grant==N) & l1v_istek_hazir_i & ~full.
  - Zero-cycle latency: a request is forwarded in the same cycle it is granted.
- Lock:
  - If l1v_istek_gecerli_o=1 and l1v_istek_hazir_i=0, set kilit=1 and kilit_id=grant at the clock edge.
  - Clear kilit on the handshake.
  - A locked requester must hold gecerli and its payload stable.
- Push: on a downstream handshake, push the granted ID (1 bit) and increment the count.
- Response routing:
  - FIFO head H selects the destination: yanitH_gecerli_o = l1v_veri_gecerli_i & ~empty, and the other yanit*_gecerli_o=0.
  - Both yanit*_veri_o = l1v_veri_i.
  - l1v_veri_hazir_o = ~empty & yanitH_hazir_i.
  - Pop on l1v_veri_gecerli_i & l1v_veri_hazir_o.
- Loads and stores: each produces exactly one response, and responses return in order.
- Simultaneous push and pop: allowed when not full; the count is unchanged and both pointers advance.
- Wrap-around: pointers are log2(DERINLIK) bits and wrap naturally. The count is a separate register, 0..DERINLIK.
- Empty with l1v_veri_gecerli_i=1: l1v_veri_hazir_o=0, no yanit asserted, and hata set sticky until reset.
- Requesters can issue back-to-back requests: one handshake per cycle maximum.

Optional Feature:
- Macro: HAKEM_DONUSUMLU_EN.
- Defined (round-robin):
  - The oncelik register holds the preferred requester.
  - After each downstream handshake, oncelik <= ~granted ID.
  - When both requesters are valid and unlocked, oncelik wins.
- Undefined (fixed priority):
  - Port 0 (bellek) always wins.
  - The oncelik register is not instantiated.

Test Plan:
- Single load: port 0 load to addr 0x0000_1000 with l1v_istek_hazir_i=1 → istek0_hazir_o=1 in the same cycle and bekleyen_sayi_o=1. Then l1v_veri_i=0xDEAD_BEEF valid → yanit0_gecerli_o=1 with 0xDEADBEEF, yanit1_gecerli_o=0, bekleyen_sayi_o back to 0.
- Contention:
  - Setup: both ports valid every cycle for 4 cycles, with l1v_istek_hazir_i=1.
  - Fixed priority: 4 grants to port 0.
  - HAKEM_DONUSUMLU_EN: grants alternate 0,1,0,1.
  - Responses return to the matching port in the same order.
- Lock:
  - Stimulus: port 1 valid with l1v_istek_hazir_i=0 for 3 cycles; port 0 raises valid in cycle 2.
  - Required: grant stays on port 1 and l1v_istek_adres_o stays equal to port 1's address. When hazir=1, port 1 handshakes and port 0 wins on the next cycle.
- Full FIFO:
  - Setup: DERINLIK=4, 4 accepted requests with no responses.
  - Required: bekleyen_sayi_o=4 and l1v_istek_gecerli_o=0 (no grant; both istek*_hazir_o=0).
  - Simultaneous pop: on the cycle a response pops, a pending request still does not push; it pushes on the next cycle, and the count returns to 4.
- Backpressure and error:
  - With head=port 1 and yanit1_hazir_i=0, a valid response → l1v_veri_hazir_o=0 and the FIFO is unchanged.
  - A response with the FIFO empty → hata_o=1 and it stays 1 until rstn_i=0.
